// File: rtl/uart_frame_loader_pkg.sv
// Shared types and defaults for the UART frame loader: FSM states, error codes,
// frame constants and frame-length helpers.
package uart_frame_loader_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned TMO_W            = 24;
    localparam int unsigned N_DEFAULT        = 2;
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT     = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_LOAD_DEFAULT = 8'h01;
    localparam logic [TMO_W-1:0]  TIMEOUT_DEFAULT  = 24'd1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_PAYLOAD   = 3'd2,
        ST_CHECK     = 3'd3,
        ST_LOAD      = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_CMD = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    // Elements per operand array.
    function automatic int unsigned elem_count(input int unsigned n);
        return n * n;
    endfunction

    // Payload bytes per frame: A array followed by B array.
    function automatic int unsigned payload_len(input int unsigned n);
        return 2 * n * n;
    endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte silence counter: counts enabled cycles since the last clear and
// flags when the configured limit has been reached.
module frame_timeout_ctr
    import uart_frame_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             expired_c
);

    localparam int unsigned CW = TMO_W + 1;

    logic [TMO_W-1:0] count_q;

    // Widened compare so a limit near the counter maximum cannot wrap.
    assign expired_c = en && ((CW'(count_q) + CW'(1)) >= CW'(limit));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr || !en) begin
            count_q <= '0;
        end else if (!expired_c) begin
            count_q <= count_q + TMO_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses framed UART bytes into the A/B operand arrays of the matrix multiplier,
// verifies the XOR checksum, launches the multiply and waits for completion.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned        N        = N_DEFAULT,
    parameter logic [BYTE_W-1:0]  SYNC     = SYNC_DEFAULT,
    parameter logic [BYTE_W-1:0]  CMD_LOAD = CMD_LOAD_DEFAULT,
    parameter logic [TMO_W-1:0]   TIMEOUT  = TIMEOUT_DEFAULT,
    localparam int unsigned       AW       = $clog2(N * N)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_error,
    input  logic              mult_done,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [AW-1:0]     wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              load_arr,
    output logic              busy,
    output logic              frame_error,
    output logic [1:0]        err_code
);

    localparam int unsigned ELEMS = elem_count(N);
    localparam int unsigned PLEN  = payload_len(N);
    localparam int unsigned IW    = $clog2(PLEN);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [IW-1:0]     idx_q, idx_d;
    err_t              err_q, err_d;

    logic              wr_en_d, wr_sel_d, load_d, busy_d, frame_error_d;
    logic [AW-1:0]     wr_addr_d;
    logic [BYTE_W-1:0] wr_data_d;

    logic              byte_ok;
    logic              in_frame;
    logic              tmo_expired_c;
    logic              abort;
    err_t              abort_code;
    logic              idx_in_b;
    logic [AW-1:0]     elem_addr;

    assign byte_ok  = rx_valid && !rx_error;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign idx_in_b = (idx_q >= IW'(ELEMS));
    assign elem_addr = idx_in_b ? AW'(idx_q - IW'(ELEMS)) : AW'(idx_q);
    assign err_code = err_q;

    frame_timeout_ctr u_timeout (
        .clk       (CLK),
        .rst_n     (RESET),
        .clr       (rx_valid || rx_error),
        .en        (in_frame),
        .limit     (TIMEOUT),
        .expired_c (tmo_expired_c)
    );

    // Next-state, checksum, payload index and registered-output decode.
    always_comb begin
        state_d       = state_q;
        chk_d         = chk_q;
        idx_d         = idx_q;
        err_d         = err_q;
        wr_en_d       = 1'b0;
        wr_sel_d      = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        load_d        = 1'b0;
        frame_error_d = 1'b0;
        abort         = 1'b0;
        abort_code    = ERR_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (byte_ok && (rx_data == SYNC)) begin
                    state_d = ST_CMD;
                    err_d   = ERR_NONE;
                    chk_d   = '0;
                    idx_d   = '0;
                end
            end

            ST_CMD, ST_PAYLOAD, ST_CHECK: begin
                // A byte arriving in the expiry cycle still counts as on time.
                if (rx_error || (!rx_valid && tmo_expired_c)) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end else if (rx_valid) begin
                    if (state_q == ST_CMD) begin
                        if (rx_data == CMD_LOAD) begin
                            state_d = ST_PAYLOAD;
                            chk_d   = rx_data;
                            idx_d   = '0;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_BAD_CMD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = idx_in_b;
                        wr_addr_d = elem_addr;
                        wr_data_d = rx_data;
                        chk_d     = chk_q ^ rx_data;
                        if (idx_q == IW'(PLEN - 1)) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        if (rx_data == chk_q) begin
                            state_d = ST_LOAD;
                            load_d  = 1'b1;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_BAD_CHK;
                        end
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (mult_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            err_d         = abort_code;
            frame_error_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            chk_q       <= '0;
            idx_q       <= '0;
            err_q       <= ERR_NONE;
            wr_en       <= 1'b0;
            wr_sel      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            load_arr    <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            wr_en       <= wr_en_d;
            wr_sel      <= wr_sel_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            load_arr    <= load_d;
            busy        <= busy_d;
            frame_error <= frame_error_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: stimulus queues expected writes, events
// and status snapshots; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_frame_loader;

    localparam int unsigned N     = 2;
    localparam int unsigned ELEMS = N * N;
    localparam int unsigned PLEN  = 2 * N * N;
    localparam int unsigned AW    = 2;
    localparam int unsigned TMO   = 100;
    localparam logic [7:0]  SYNC_B = 8'hA5;
    localparam logic [7:0]  CMD_B  = 8'h01;
    localparam logic [2:0]  EV_LOAD = 3'b100;

    localparam int K_GOOD = 0, K_BADCHK = 1, K_BADCMD = 2, K_TMO = 3, K_RXERR = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          rx_valid, rx_error, mult_done;
    logic [7:0]    rx_data;
    logic          wr_en, wr_sel, load_arr, busy, frame_error;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    err_code;

    always #5 CLK = ~CLK;

    uart_frame_loader #(.N(N), .TIMEOUT(24'(TMO))) dut (
        .CLK(CLK), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .mult_done(mult_done), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .load_arr(load_arr), .busy(busy),
        .frame_error(frame_error), .err_code(err_code)
    );

    typedef struct packed { logic sel; logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic all_zero; logic busy; logic [1:0] code; logic load_now; logic drained; } st_t;

    wr_t        wq[$];
    logic [2:0] evq[$];
    st_t        stq[$];
    wr_t        mw;
    logic [2:0] me;
    st_t        ms;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;
    logic [7:0] pl [PLEN];
    logic [1:0] last_code;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected at %0t", name, got, $time);
    endfunction

    // Monitor: compare every DUT output event and queued status snapshot.
    always @(negedge CLK) begin
        if (wr_en) begin
            if (wq.size() == 0) unexpected("write", 32'({wr_sel, wr_addr, wr_data}));
            else begin
                mw = wq.pop_front();
                chk("write", 32'({wr_sel, wr_addr, wr_data}), 32'({mw.sel, mw.addr, mw.data}));
            end
        end
        if (load_arr) begin
            if (evq.size() == 0) unexpected("load_arr", 32'(EV_LOAD));
            else begin
                me = evq.pop_front();
                chk("load_event", 32'(EV_LOAD), 32'(me));
            end
        end
        if (frame_error) begin
            if (evq.size() == 0) unexpected("frame_error", 32'(err_code));
            else begin
                me = evq.pop_front();
                chk("error_event", 32'({1'b0, err_code}), 32'(me));
            end
        end
        if (stq.size() > 0) begin
            ms = stq.pop_front();
            if (ms.all_zero) begin
                chk("reset_outputs", 32'({wr_en, wr_sel, wr_addr, wr_data, load_arr, busy, frame_error, err_code}), 32'(0));
            end else begin
                chk("busy", 32'(busy), 32'(ms.busy));
                chk("err_code", 32'(err_code), 32'(ms.code));
                if (ms.load_now) chk("load_latency", 32'(load_arr), 32'(1));
                if (ms.drained) chk("pending_outputs", 32'(wq.size() + evq.size()), 32'(0));
            end
        end
        if (done) begin
            chk("final_queues", 32'(wq.size() + evq.size() + stq.size()), 32'(0));
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_error = err;
        tick(1);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic gap();
        tick(int'($urandom_range(0, 3)));
    endtask

    task automatic push_stat(input logic b, input logic [1:0] c, input logic ld, input logic dr);
        stq.push_back('{1'b0, b, c, ld, dr});
    endtask

    // Payload byte i lands in A for the first N*N bytes, then B, row-major.
    task automatic send_payload(input int k);
        for (int i = 0; i < k; i++) begin
            wq.push_back('{(i >= int'(ELEMS)), AW'(i % int'(ELEMS)), pl[i]});
            send_byte(pl[i], 1'b0);
            if (i != k - 1) gap();
        end
    endtask

    task automatic run_frame(input int kind, input int k, input logic [7:0] alt);
        logic [7:0] sum;
        sum = CMD_B;
        for (int i = 0; i < int'(PLEN); i++) sum = sum ^ pl[i];
        send_byte(SYNC_B, 1'b0);
        gap();
        case (kind)
            K_BADCMD: begin
                evq.push_back({1'b0, 2'd1});
                send_byte(alt, 1'b0);
                tick(2);
                push_stat(1'b0, 2'd1, 1'b0, 1'b1);
                last_code = 2'd1;
            end
            K_TMO: begin
                send_byte(CMD_B, 1'b0);
                gap();
                send_payload(k);
                evq.push_back({1'b0, 2'd3});
                tick(int'(TMO) - 10);
                push_stat(1'b1, 2'd0, 1'b0, 1'b0);
                tick(13);
                push_stat(1'b0, 2'd3, 1'b0, 1'b1);
                last_code = 2'd3;
            end
            K_RXERR: begin
                send_byte(CMD_B, 1'b0);
                gap();
                send_payload(k);
                gap();
                evq.push_back({1'b0, 2'd3});
                send_byte(8'($urandom), 1'b1);
                tick(2);
                push_stat(1'b0, 2'd3, 1'b0, 1'b1);
                last_code = 2'd3;
            end
            K_BADCHK: begin
                send_byte(CMD_B, 1'b0);
                gap();
                send_payload(int'(PLEN));
                gap();
                evq.push_back({1'b0, 2'd2});
                send_byte(sum ^ alt, 1'b0);
                tick(2);
                push_stat(1'b0, 2'd2, 1'b0, 1'b1);
                last_code = 2'd2;
            end
            default: begin
                send_byte(CMD_B, 1'b0);
                gap();
                send_payload(int'(PLEN));
                gap();
                evq.push_back(EV_LOAD);
                send_byte(sum, 1'b0);
                push_stat(1'b1, 2'd0, 1'b1, 1'b0);
                mult_done = 1'b1;          // seen in the LOAD cycle: must not count
                tick(1);
                mult_done = 1'b0;
                push_stat(1'b1, 2'd0, 1'b0, 1'b0);
                for (int j = 0; j < 3; j++) begin
                    send_byte((j == 0) ? SYNC_B : 8'($urandom), 1'b0);
                    gap();
                end
                push_stat(1'b1, 2'd0, 1'b0, 1'b1);
                tick(int'($urandom_range(0, 5)));
                mult_done = 1'b1;
                tick(1);
                mult_done = 1'b0;
                tick(2);
                push_stat(1'b0, 2'd0, 1'b0, 1'b1);
                last_code = 2'd0;
            end
        endcase
    endtask

    initial begin
        int kind, k;
        logic [7:0] alt;
        RESET = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0; mult_done = 1'b0;
        last_code = 2'd0;
        tick(3);
        stq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        tick(1);
        RESET = 1'b1;
        tick(2);
        push_stat(1'b0, 2'd0, 1'b0, 1'b1);

        for (int i = 0; i < int'(PLEN); i++) pl[i] = 8'(i + 1);
        run_frame(K_GOOD, 0, 8'h00);
        run_frame(K_BADCHK, 0, 8'h09);
        run_frame(K_BADCMD, 0, 8'h02);
        pl[0] = 8'h11; pl[1] = 8'h22;
        run_frame(K_TMO, 2, 8'h00);
        for (int i = 0; i < int'(PLEN); i++) pl[i] = 8'(i + 1);
        run_frame(K_GOOD, 0, 8'h00);
        run_frame(K_RXERR, 3, 8'h00);

        // Reset mid-payload discards the frame.
        send_byte(SYNC_B, 1'b0);
        send_byte(CMD_B, 1'b0);
        send_payload(2);
        tick(2);
        RESET = 1'b0;
        tick(1);
        stq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        RESET = 1'b1;
        tick(5);
        push_stat(1'b0, 2'd0, 1'b0, 1'b1);
        last_code = 2'd0;

        for (int it = 0; it < 30; it++) begin
            // Idle junk: non-sync byte, lone rx_error, and sync dropped by rx_error.
            send_byte(8'h5A ^ 8'($urandom_range(0, 15)), 1'b0);
            send_byte(8'($urandom), 1'b1);
            send_byte(SYNC_B, 1'b1);
            tick(1);
            push_stat(1'b0, last_code, 1'b0, 1'b1);
            for (int i = 0; i < int'(PLEN); i++)
                pl[i] = ($urandom_range(0, 7) == 0) ? SYNC_B : 8'($urandom);
            k = $urandom_range(0, 9);
            kind = (k < 4) ? K_GOOD : (k < 6) ? K_BADCHK : (k == 6) ? K_BADCMD : (k == 7) ? K_TMO : K_RXERR;
            alt = (kind == K_BADCMD) ? 8'($urandom) : 8'($urandom_range(1, 255));
            if (kind == K_BADCMD && alt == CMD_B) alt = 8'h02;
            run_frame(kind, int'($urandom_range(0, PLEN)) % (kind == K_TMO ? int'(PLEN) : int'(PLEN) + 1), alt);
        end
        tick(3);
        done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
